// File: rtl/onewire_byte_if.sv
// ============================================================================
// Module      : onewire_byte_if
// Description : Host-side command/response handshake bundle for onewire_byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface onewire_byte_if #(
    parameter int BITS = 8
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic            cmd_od;
    logic [BITS-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_data;
    logic            rsp_presence;

    modport master (
        output cmd_valid, cmd_op, cmd_od, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_od, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence
    );
endinterface

`default_nettype wire

// File: rtl/onewire_byte.sv
// ============================================================================
// Module      : onewire_byte
// Description : Sequences reset/presence and LSB-first byte transfers over a
//               downstream 1-Wire bit master, one bit cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onewire_byte #(
    parameter int BITS = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    onewire_byte_if.slave    host,
    output logic             bit_req,
    output logic             bit_rst,
    output logic             bit_od,
    output logic             bit_dtx,
    input  wire logic        bit_ack,
    input  wire logic        bit_drx,
    output logic             busy
);

    localparam int                  c_cnt_w    = $clog2(BITS + 1);
    localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [BITS-1:0]     c_bit_one  = BITS'(1);
    localparam logic [1:0]          c_op_reset = 2'b00;
    localparam logic [1:0]          c_op_read  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_op;
    logic                r_od;
    logic [BITS-1:0]     r_data;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [BITS-1:0]     r_rsp_data;
    logic                r_presence;

    logic [BITS-1:0]     w_data_shift;
    logic [BITS-1:0]     w_bit_mask;
    logic                w_tx_bit;
    logic                w_last;

    assign w_data_shift = r_data >> r_cnt;
    assign w_bit_mask   = c_bit_one << r_cnt;
    // Reset pulses and read slots both release the line (transmit 1).
    assign w_tx_bit     = ((r_op == c_op_reset) || (r_op == c_op_read)) ? 1'b1 : w_data_shift[0];
    assign w_last       = (r_op == c_op_reset) || (r_cnt == c_last_cnt);

    assign host.rsp_data     = r_rsp_data;
    assign host.rsp_presence = r_presence;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        bit_req        = 1'b0;
        bit_rst        = 1'b0;
        bit_od         = 1'b0;
        bit_dtx        = 1'b0;
        busy           = 1'b1;
        case (r_state)
            IDLE: begin
                host.cmd_ready = 1'b1;
                busy           = 1'b0;
                if (host.cmd_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                bit_req = 1'b1;
                bit_rst = (r_op == c_op_reset);
                bit_od  = r_od;
                bit_dtx = w_tx_bit;
                if (bit_ack && w_last) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op       <= 2'b00;
            r_od       <= 1'b0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_presence <= 1'b0;
        end else if ((r_state == IDLE) && host.cmd_valid) begin
            r_op       <= host.cmd_op;
            r_od       <= host.cmd_od;
            r_data     <= host.cmd_data;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_presence <= 1'b0;
        end else if ((r_state == ISSUE) && bit_ack) begin
            if (r_op == c_op_reset) begin
                r_presence <= ~bit_drx;
            end else begin
                r_rsp_data <= bit_drx ? (r_rsp_data | w_bit_mask) : (r_rsp_data & ~w_bit_mask);
                // Counter parks on the last index; leaving ISSUE ends the transfer.
                if (!w_last) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_onewire_byte.sv
// ============================================================================
// Module      : tb_onewire_byte
// Description : Randomized and directed self-checking bench for onewire_byte
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onewire_byte;

    localparam int BITS = 8;

    logic clk = 1'b0;
    logic rst;
    logic bit_req, bit_rst, bit_od, bit_dtx;
    logic bit_ack, bit_drx;
    logic busy;

    onewire_byte_if #(.BITS(BITS)) host_if ();

    onewire_byte #(.BITS(BITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .host    (host_if),
        .bit_req (bit_req),
        .bit_rst (bit_rst),
        .bit_od  (bit_od),
        .bit_dtx (bit_dtx),
        .bit_ack (bit_ack),
        .bit_drx (bit_drx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: one outstanding command, acks received so far.
    bit              m_busy = 1'b0;
    int              m_k    = 0;
    int              m_nb   = 0;
    logic [1:0]      m_op   = 2'b00;
    logic            m_od   = 1'b0;
    logic [BITS-1:0] m_data = '0;
    logic [BITS-1:0] m_rx   = '0;
    logic            m_pres = 1'b0;
    bit              m_accepted = 1'b0;

    // Bit-master emulation controls
    int              ack_fixed  = -1;
    int              ack_target = 0;
    int              ack_wait   = 0;
    int              drx_mode   = 0;
    logic [BITS-1:0] drx_pat    = '0;
    bit              spur_en    = 1'b0;
    logic            dtx_log[$];
    logic            rst_log[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic exp_dtx;
        if (rst) chk1("cmd_ready", host_if.cmd_ready, !m_busy);
        chk1("busy", busy, m_busy);
        chk1("bit_req", bit_req, m_busy && (m_k < m_nb));
        chk1("rsp_valid", host_if.rsp_valid, m_busy && (m_k == m_nb));
        if (m_busy && (m_k < m_nb)) begin
            exp_dtx = ((m_op == 2'b01) || (m_op == 2'b11)) ? m_data[m_k] : 1'b1;
            chk1("bit_rst", bit_rst, m_op == 2'b00);
            chk1("bit_od", bit_od, m_od);
            chk1("bit_dtx", bit_dtx, exp_dtx);
        end
        if (m_busy && (m_k == m_nb)) begin
            chkd("rsp_data", host_if.rsp_data, (m_op == 2'b00) ? '0 : m_rx);
            chk1("rsp_presence", host_if.rsp_presence, (m_op == 2'b00) ? m_pres : 1'b0);
        end
    endtask

    // Called at a negedge once the inputs for the coming edge are set.
    task automatic cycle();
        if (bit_req === 1'b1) begin
            if (ack_wait >= ack_target) begin
                bit_ack = 1'b1;
                case (drx_mode)
                    1:       bit_drx = bit_dtx;
                    2:       bit_drx = (m_k < BITS) ? drx_pat[m_k] : 1'b0;
                    default: bit_drx = 1'($urandom_range(0, 1));
                endcase
                dtx_log.push_back(bit_dtx);
                rst_log.push_back(bit_rst);
                ack_wait   = 0;
                ack_target = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
            end else begin
                bit_ack = 1'b0;
                ack_wait++;
            end
        end else begin
            bit_ack    = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bit_drx    = 1'($urandom_range(0, 1));
            ack_wait   = 0;
            ack_target = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
        end

        m_accepted = 1'b0;
        if (!rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_nb   = 0;
        end else if (m_busy && (m_k == m_nb)) begin
            if (host_if.rsp_ready) m_busy = 1'b0;
        end else if (m_busy) begin
            if (bit_ack) begin
                if (m_op == 2'b00) m_pres = ~bit_drx;
                else               m_rx[m_k] = bit_drx;
                m_k++;
            end
        end else if (host_if.cmd_valid) begin
            m_busy     = 1'b1;
            m_op       = host_if.cmd_op;
            m_od       = host_if.cmd_od;
            m_data     = host_if.cmd_data;
            m_nb       = (host_if.cmd_op == 2'b00) ? 1 : BITS;
            m_k        = 0;
            m_rx       = '0;
            m_pres     = 1'b0;
            m_accepted = 1'b1;
        end

        @(negedge clk);
        compare();
    endtask

    task automatic reset_state_check();
        chk1("rst_bit_req", bit_req, 1'b0);
        chk1("rst_bit_rst", bit_rst, 1'b0);
        chk1("rst_bit_od", bit_od, 1'b0);
        chk1("rst_bit_dtx", bit_dtx, 1'b0);
        chk1("rst_rsp_valid", host_if.rsp_valid, 1'b0);
        chk1("rst_rsp_presence", host_if.rsp_presence, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkd("rst_rsp_data", host_if.rsp_data, '0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic od, input logic [BITS-1:0] data);
        int n;
        host_if.cmd_valid = 1'b1;
        host_if.cmd_op    = op;
        host_if.cmd_od    = od;
        host_if.cmd_data  = data;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!m_accepted && (n < 50));
        host_if.cmd_valid = 1'b0;
        if (!m_accepted) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: command not accepted within 50 cycles at %0t", $time);
        end
    endtask

    task automatic wait_rsp(input int limit);
        int n;
        n = 0;
        while ((host_if.rsp_valid !== 1'b1) && (n < limit)) begin
            cycle();
            n++;
        end
        if (host_if.rsp_valid !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles at %0t", limit, $time);
        end
    endtask

    task automatic release_rsp();
        host_if.rsp_ready = 1'b1;
        cycle();
        host_if.rsp_ready = 1'b0;
    endtask

    function automatic logic [BITS-1:0] pack_log();
        logic [BITS-1:0] v;
        v = '0;
        for (int i = 0; i < dtx_log.size() && i < BITS; i++) v[i] = dtx_log[i];
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic all_ones;
        int   n;

        rst               = 1'b0;
        bit_ack           = 1'b0;
        bit_drx           = 1'b0;
        host_if.cmd_valid = 1'b0;
        host_if.cmd_op    = 2'b00;
        host_if.cmd_od    = 1'b0;
        host_if.cmd_data  = '0;
        host_if.rsp_ready = 1'b0;

        @(negedge clk);
        cycle();
        cycle();
        reset_state_check();
        rst = 1'b1;
        cycle();
        chk1("ready_after_reset", host_if.cmd_ready, 1'b1);

        // Spurious acks while idle must be ignored
        spur_en = 1'b1;
        repeat (10) cycle();
        spur_en = 1'b0;

        // Reset/presence with line pulled low by a device
        drx_mode = 2; drx_pat = '0; dtx_log.delete(); rst_log.delete();
        run_cmd(2'b00, 1'b0, 8'h5A);
        wait_rsp(100);
        chk1("presence_lit", host_if.rsp_presence, 1'b1);
        chkd("presence_data_lit", host_if.rsp_data, 8'h00);
        chki("presence_slots", dtx_log.size(), 1);
        if (rst_log.size() > 0) chk1("presence_bit_rst", rst_log[0], 1'b1);
        if (dtx_log.size() > 0) chk1("presence_bit_dtx", dtx_log[0], 1'b1);
        release_rsp();
        chk1("b2b_ready", host_if.cmd_ready, 1'b1);

        // Write 0xA5 with echoing line
        drx_mode = 1; dtx_log.delete(); rst_log.delete();
        run_cmd(2'b01, 1'b0, 8'hA5);
        wait_rsp(200);
        chki("write_slots", dtx_log.size(), 8);
        chkd("write_dtx_seq", pack_log(), 8'b1010_0101);
        chkd("write_data_lit", host_if.rsp_data, 8'hA5);
        chk1("write_presence_lit", host_if.rsp_presence, 1'b0);
        release_rsp();

        // Read slots sampling 0,1,1,0,0,0,0,1
        drx_mode = 2; drx_pat = 8'b1000_0110; dtx_log.delete(); rst_log.delete();
        run_cmd(2'b10, 1'b1, 8'h00);
        wait_rsp(200);
        all_ones = 1'b1;
        foreach (dtx_log[i]) all_ones &= dtx_log[i];
        chki("read_slots", dtx_log.size(), 8);
        chk1("read_dtx_all_ones", all_ones, 1'b1);
        chkd("read_data_lit", host_if.rsp_data, 8'h86);
        release_rsp();

        // Response held back for 20 cycles while another command is offered
        drx_mode = 1;
        run_cmd(2'b11, 1'b0, 8'h3C);
        wait_rsp(200);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_op    = 2'b01;
        host_if.cmd_data  = 8'hFF;
        repeat (20) begin
            cycle();
            chkd("hold_rsp_data", host_if.rsp_data, 8'h3C);
        end
        chk1("hold_no_ready", host_if.cmd_ready, 1'b0);
        host_if.cmd_valid = 1'b0;
        release_rsp();

        // Reset after the third bit ack of a write
        ack_fixed = 2;
        run_cmd(2'b01, 1'b0, 8'hF0);
        n = 0;
        while ((m_k < 3) && (n < 100)) begin
            cycle();
            n++;
        end
        chki("abort_acks", m_k, 3);
        rst = 1'b0;
        cycle();
        reset_state_check();
        rst = 1'b1;
        repeat (3) cycle();
        ack_fixed = -1; dtx_log.delete();
        run_cmd(2'b01, 1'b0, 8'h0F);
        wait_rsp(200);
        chki("restart_slots", dtx_log.size(), 8);
        chkd("restart_dtx_seq", pack_log(), 8'h0F);
        chkd("restart_data_lit", host_if.rsp_data, 8'h0F);
        release_rsp();

        // Bit master stalls 100 cycles on every slot
        ack_fixed = 100;
        run_cmd(2'b11, 1'b1, 8'h96);
        wait_rsp(2000);
        chkd("slow_data_lit", host_if.rsp_data, 8'h96);
        release_rsp();
        ack_fixed = -1;

        // Randomized traffic with random stalls, back-pressure and resets
        drx_mode = 0;
        spur_en  = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (m_accepted) host_if.cmd_valid = 1'b0;
            if (!host_if.cmd_valid && ($urandom_range(0, 3) == 0)) begin
                host_if.cmd_valid = 1'b1;
                host_if.cmd_op    = 2'($urandom_range(0, 3));
                host_if.cmd_od    = 1'($urandom_range(0, 1));
                host_if.cmd_data  = BITS'($urandom);
            end
            host_if.rsp_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst = 1'b1;
        host_if.cmd_valid = 1'b0;
        host_if.rsp_ready = 1'b1;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onewire_byte.md
ONEWIRE_BYTE -- requirements
Module: onewire_byte

Interface
REQ-001 SHALL provide parameter BITS, default 8: bits per byte transfer, range 1 to 16.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port cmd_valid  input  1  command offered by the host.
REQ-005 SHALL provide port cmd_ready  output  1  block accepts a command.
REQ-006 SHALL provide port cmd_op  input  2  operation: 00 reset/presence, 01 write byte, 10 read byte, 11 write byte.
REQ-007 SHALL provide port cmd_od  input  1  overdrive select for this command.
REQ-008 SHALL provide port cmd_data  input  BITS  byte to transmit, LSB first.
REQ-009 SHALL provide port rsp_valid  output  1  response available.
REQ-010 SHALL provide port rsp_ready  input  1  host accepts the response.
REQ-011 SHALL provide port rsp_data  output  BITS  sampled line bits, LSB first.
REQ-012 SHALL provide port rsp_presence  output  1  presence detected (reset op only, else 0).
REQ-013 SHALL provide port bit_req  output  1  bit cycle request to the downstream onewire bit master.
REQ-014 SHALL provide port bit_rst  output  1  requested cycle is a reset pulse.
REQ-015 SHALL provide port bit_od  output  1  overdrive for the requested cycle.
REQ-016 SHALL provide port bit_dtx  output  1  bit value to transmit.
REQ-017 SHALL provide port bit_ack  input  1  single-cycle pulse: bit master finished the cycle.
REQ-018 SHALL provide port bit_drx  input  1  sampled line value, valid when bit_ack=1.
REQ-019 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-021 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&cmd_ready.
REQ-022 SHALL on acceptance latch cmd_op, cmd_od, cmd_data, clear bit counter and rsp_data, and enter ISSUE next cycle.
REQ-023 SHALL in ISSUE hold bit_req=1 with bit_rst, bit_od, bit_dtx stable until bit_ack=1.
REQ-024 SHALL for op 00 issue exactly one cycle with bit_rst=1, bit_dtx=1; on bit_ack set rsp_presence=~bit_drx and go to RESP.
REQ-025 SHALL for op 01/11 issue BITS cycles with bit_rst=0, bit_dtx=latched data bit[n], n=0..BITS-1.
REQ-026 SHALL for op 10 issue BITS cycles with bit_rst=0, bit_dtx=1 (read slot).
REQ-027 SHALL on each bit_ack in a data op store bit_drx into rsp_data[n] and increment n.
REQ-028 SHALL on bit_ack with n=BITS-1 go to RESP; otherwise stay in ISSUE with bit_req remaining 1 and new bit_dtx next cycle.
REQ-029 SHALL deassert bit_req in the cycle after the final bit_ack (registered output, one idle cycle between commands minimum).
REQ-030 SHALL ignore bit_ack when bit_req=0.
REQ-031 SHALL in RESP assert rsp_valid with rsp_data/rsp_presence stable until rsp_ready=1, then return to IDLE next cycle.
REQ-032 SHALL hold rsp_valid indefinitely under rsp_ready=0 and not accept commands meanwhile.
REQ-033 SHALL set rsp_presence=0 for data ops and rsp_data=0 for reset op.
REQ-034 SHALL size the bit counter to $clog2(BITS+1) bits with no wrap beyond BITS-1.
REQ-035 SHALL accept a new command in the cycle IDLE is re-entered (back-to-back latency: response handshake to next cmd_ready = 1 cycle).

Reset
REQ-036 SHALL on rst=0 at a clock edge enter IDLE, with cmd_ready=1 (once rst=1), rsp_valid=0, bit_req=0, bit_rst=0, bit_od=0, bit_dtx=0, rsp_data=0, rsp_presence=0, busy=0.
REQ-037 SHALL abort any transfer on reset mid-operation; bit_req drops the cycle after the reset edge and no response is produced.

Verification
REQ-038 Reset op, bit master returns bit_drx=0 -> one bit_req with bit_rst=1, rsp_valid with rsp_presence=1, rsp_data=0x00.
REQ-039 Write 0xA5, bit_drx echoes bit_dtx -> 8 bit cycles with bit_dtx sequence 1,0,1,0,0,1,0,1, rsp_data=0xA5, rsp_presence=0.
REQ-040 Read op, bit_drx sequence 0,1,1,0,0,0,0,1 -> all bit_dtx=1, rsp_data=0x86.
REQ-041 rsp_ready held 0 for 20 cycles after completion -> rsp_valid and rsp_data stable, cmd_ready=0, no bit_req.
REQ-042 rst=0 asserted after 3rd bit_ack of a write -> bit_req=0 next cycle, rsp_valid never asserted, next command executes from bit 0.
REQ-043 Spurious bit_ack while IDLE and bit_ack delayed 100 cycles in ISSUE -> no state change in IDLE, bit_req/bit_dtx held stable for all 100 cycles.
